serial_frame_transmitter: RTL and testbench
===========================================

SERIAL_FRAME_TRANSMITTER -- requirements
Module: serial_frame_transmitter

Interface
REQ-001 Parameter DATA_WIDTH, default 4: payload bits per frame, legal range 2..16.
REQ-002 Parameter PARITY_EN, default 1: 1 inserts an even-parity bit after the payload; 0 omits it.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 in_data  input  DATA_WIDTH  parallel word to transmit.
REQ-006 in_valid  input  1  in_data is offered this cycle.
REQ-007 in_ready  output  1  block accepts a word this cycle.
REQ-008 data_out  output  1  serial line, idle high.
REQ-009 busy  output  1  a frame is in progress.
REQ-010 tx_done  output  1  one-cycle pulse during the stop-bit cycle.

Function
REQ-011 A word SHALL be accepted only on a rising edge where in_valid and in_ready are both 1; in_data is captured into an internal shift register on that edge.
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
- IDLE -> START on accept.
- START -> DATA after 1 cycle.
- DATA -> PARITY after DATA_WIDTH cycles if PARITY_EN=1, else -> STOP.
- PARITY -> STOP after 1 cycle.
- STOP -> START on accept, else -> IDLE.
REQ-013 data_out SHALL be registered:
- 1 in IDLE and STOP.
- 0 in START.
- Captured bit i in DATA cycle i, LSB first.
- XOR of all captured bits in PARITY.
REQ-014 Frame length SHALL be DATA_WIDTH+2+PARITY_EN cycles. The start bit appears on data_out in the cycle immediately after the accepting edge.
REQ-015 in_ready SHALL be 1 exactly in IDLE and STOP, allowing back-to-back frames with no idle gap.
REQ-016 busy SHALL be 1 in START, DATA, PARITY and STOP, and 0 in IDLE.
REQ-017 tx_done SHALL be 1 for exactly the single STOP cycle of each frame.
REQ-018 The bit counter SHALL count 0..DATA_WIDTH-1, be cleared on entry to DATA, and never wrap inside a frame.
REQ-019 in_data and in_valid changes while in_ready=0 SHALL have no effect on the frame in progress.
REQ-020 in_valid held high continuously SHALL produce one frame per accepted word, with no word duplicated or dropped.

Reset
REQ-021 While rst=0 the block SHALL hold, independent of clk:
- FSM in IDLE.
- data_out=1, busy=0, tx_done=0, in_ready=1.
- Bit counter and shift register at 0.
REQ-022 Reset asserted mid-frame SHALL abort the frame immediately and discard the word. The first frame after release starts only on a new accept.

Structure
REQ-023 The state encoding (3-bit constants for IDLE, START, DATA, PARITY, STOP) and the line-idle level constant SHALL live in the shared package.
REQ-024 The load/shift datapath SHALL be one sub-module, parallel_in_serial_out_register: parallel load, right shift, LSB out. The FSM, counter and parity logic stay in the top module.

Verification
REQ-025 Reset idle, DATA_WIDTH=4, PARITY_EN=1: after release with in_valid=0 for 10 cycles -> data_out=1, busy=0, in_ready=1, tx_done=0.
REQ-026 Single frame, in_data=4'b1011 accepted at edge N -> data_out sequence 0,1,1,0,1,1(parity),1(stop) starting cycle N+1; tx_done high in cycle N+7 only.
REQ-027 Back-to-back frames: in_valid held high with 4'b0001 then 4'b1110 -> second start bit immediately follows the first stop bit; parity bits 1 then 1; 14 busy cycles total.
REQ-028 PARITY_EN=0, in_data=4'b0110 -> data_out 0,0,1,1,0,1; frame length 6 cycles.
REQ-029 Reset mid-frame: rst driven 0 during DATA bit 2 -> data_out=1 and busy=0 immediately without a clock edge; no tx_done; next accepted word transmits correctly.
REQ-030 Stability: in_data toggled every cycle while busy and in_ready=0 -> transmitted bits match only the accepted word.

Source files
------------

// File: rtl/serial_frame_transmitter_pkg.sv
// Shared definitions for the serial frame transmitter.
//   state_e  : FSM state encoding (3-bit)
//   LineIdle : level driven on the serial line when no frame is in progress
package serial_frame_transmitter_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } state_e;

    localparam logic LineIdle = 1'b1;

endpackage

// File: rtl/parallel_in_serial_out_register.sv
// Load/shift datapath: parallel load, right shift with zero fill, LSB presented on lsb_o.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset, clears the register
//   load_i  : capture data_i (has priority over shift_i)
//   shift_i : shift right by one
//   data_i  : parallel word
//   lsb_o   : current least-significant bit
module parallel_in_serial_out_register #(
    parameter int unsigned Width = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [Width-1:0] data_i,
    output logic             lsb_o
);

    logic [Width-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = data_i;
        end else if (shift_i) begin
            sr_d = {1'b0, sr_q[Width-1:1]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign lsb_o = sr_q[0];

endmodule

// File: rtl/serial_frame_transmitter.sv
// Serial frame transmitter: start bit (0), DATA_WIDTH payload bits LSB first, optional
// even-parity bit, stop bit (1). Back-to-back frames are accepted during the stop bit.
//   clk      : clock
//   rst      : asynchronous active-low reset
//   in_data  : parallel word to transmit
//   in_valid : in_data offered this cycle
//   in_ready : word accepted on this edge if in_valid (IDLE or STOP)
//   data_out : registered serial line, idle high
//   busy     : frame in progress
//   tx_done  : high during the stop-bit cycle
module serial_frame_transmitter
    import serial_frame_transmitter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 4,
    parameter bit          PARITY_EN  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  data_out,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int unsigned CntW    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              parity_q, parity_d;
    logic              data_out_q, data_out_d;
    logic              accept;
    logic              load;
    logic              shift;
    logic              sr_lsb;

    assign in_ready = (state_q == StIdle) || (state_q == StStop);
    assign busy     = (state_q != StIdle);
    assign tx_done  = (state_q == StStop);
    assign data_out = data_out_q;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        parity_d   = parity_q;
        data_out_d = LineIdle;
        load       = accept;
        shift      = 1'b0;

        if (accept) begin
            parity_d = ^in_data;
        end

        unique case (state_q)
            StIdle: begin
                if (accept) state_d = StStart;
            end
            StStart: begin
                state_d = StData;
                cnt_d   = '0;
            end
            StData: begin
                if (cnt_q == LastBit) begin
                    state_d = PARITY_EN ? StParity : StStop;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StParity: begin
                state_d = StStop;
            end
            StStop: begin
                state_d = accept ? StStart : StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Line level is registered from the state being entered. Each shift happens on
        // the edge that puts the current LSB onto the line, so the next bit is ready.
        unique case (state_d)
            StStart:  data_out_d = 1'b0;
            StData: begin
                data_out_d = sr_lsb;
                shift      = 1'b1;
            end
            StParity: data_out_d = parity_q;
            default:  data_out_d = LineIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            parity_q   <= 1'b0;
            data_out_q <= LineIdle;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            parity_q   <= parity_d;
            data_out_q <= data_out_d;
        end
    end

    parallel_in_serial_out_register #(
        .Width (DATA_WIDTH)
    ) u_piso (
        .clk_i   (clk),
        .rst_ni  (rst),
        .load_i  (load),
        .shift_i (shift),
        .data_i  (in_data),
        .lsb_o   (sr_lsb)
    );

endmodule

// File: tb/tb_serial_frame_transmitter.sv
// Bench for serial_frame_transmitter: one instance with parity, one without. A driver
// pushes the expected line waveform of each accepted word into a per-instance queue; a
// monitor rebuilds frames from data_out and compares them on tx_done.
module tb_serial_frame_transmitter;

    typedef struct {
        logic [15:0] bits;
        int          len;
    } frame_t;

    logic       clk;
    logic       rst;
    logic [3:0] din  [2];
    logic       vld  [2];
    logic       rdy  [2];
    logic       dout [2];
    logic       bsy  [2];
    logic       done [2];

    frame_t      exp0[$];
    frame_t      exp1[$];
    logic [15:0] col     [2];
    int          col_len [2];
    int          bsy_cnt [2];

    int n_tests = 0;
    int n_fail  = 0;

    serial_frame_transmitter #(
        .DATA_WIDTH (4),
        .PARITY_EN  (1'b1)
    ) u_dut_par (
        .clk      (clk),
        .rst      (rst),
        .in_data  (din[0]),
        .in_valid (vld[0]),
        .in_ready (rdy[0]),
        .data_out (dout[0]),
        .busy     (bsy[0]),
        .tx_done  (done[0])
    );

    serial_frame_transmitter #(
        .DATA_WIDTH (4),
        .PARITY_EN  (1'b0)
    ) u_dut_nopar (
        .clk      (clk),
        .rst      (rst),
        .in_data  (din[1]),
        .in_valid (vld[1]),
        .in_ready (rdy[1]),
        .data_out (dout[1]),
        .busy     (bsy[1]),
        .tx_done  (done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the line waveform of one frame, first transmitted bit in bit 0.
    function automatic frame_t model_frame(input logic [3:0] w, input bit par);
        frame_t f;
        int     k;
        f.bits = '0;
        k = 0;
        f.bits[k] = 1'b0;
        k++;
        for (int i = 0; i < 4; i++) begin
            f.bits[k] = w[i];
            k++;
        end
        if (par) begin
            f.bits[k] = ($countones(w) % 2) == 1;
            k++;
        end
        f.bits[k] = 1'b1;
        k++;
        f.len = k;
        return f;
    endfunction

    task automatic send(input int s, input logic [3:0] w, input bit hold);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 64 && !ok; t++) begin
            @(negedge clk);
            if (rdy[s]) begin
                din[s] = w;
                vld[s] = 1'b1;
                ok     = 1'b1;
            end else begin
                // Noise on the inputs while the block is not ready.
                din[s] = 4'($urandom);
                vld[s] = 1'($urandom);
            end
        end
        if (!ok) begin
            check("accept_timeout", 0, 1);
            return;
        end
        if (s == 0) exp0.push_back(model_frame(w, 1'b1));
        else        exp1.push_back(model_frame(w, 1'b0));
        @(posedge clk);
        #1;
        if (!hold) vld[s] = 1'b0;
        din[s] = 4'($urandom);
        @(negedge clk);
        check("start_bit", int'(dout[s]), 0);
        check("busy_at_start", int'(bsy[s]), 1);
    endtask

    task automatic wait_idle(input int s);
        bit idle;
        idle = 1'b0;
        for (int t = 0; t < 40 && !idle; t++) begin
            @(negedge clk);
            if (!bsy[s]) idle = 1'b1;
        end
        if (!idle) check("idle_timeout", 0, 1);
    endtask

    task automatic check_idle(input int s);
        check("idle_data_out", int'(dout[s]), 1);
        check("idle_busy", int'(bsy[s]), 0);
        check("idle_in_ready", int'(rdy[s]), 1);
        check("idle_tx_done", int'(done[s]), 0);
    endtask

    // Monitor: collect line bits while busy, compare a whole frame on tx_done.
    initial begin
        frame_t e;
        bit     empty;
        for (int s = 0; s < 2; s++) begin
            col[s]     = '0;
            col_len[s] = 0;
            bsy_cnt[s] = 0;
        end
        forever begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                if (!rst) begin
                    col[s]     = '0;
                    col_len[s] = 0;
                end else if (bsy[s]) begin
                    bsy_cnt[s]++;
                    if (col_len[s] < 16) col[s][col_len[s]] = dout[s];
                    col_len[s]++;
                    if (done[s]) begin
                        check("ready_in_stop", int'(rdy[s]), 1);
                        empty = (s == 0) ? (exp0.size() == 0) : (exp1.size() == 0);
                        if (empty) begin
                            check("unexpected_frame", 1, 0);
                        end else begin
                            e = (s == 0) ? exp0.pop_front() : exp1.pop_front();
                            check("frame_bits", int'(col[s]), int'(e.bits));
                            check("frame_len", col_len[s], e.len);
                        end
                        col[s]     = '0;
                        col_len[s] = 0;
                    end
                end else if (done[s]) begin
                    check("done_without_busy", 1, 0);
                end
            end
        end
    end

    initial begin
        int b;
        int nw;
        int s;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            din[i] = '0;
            vld[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check_idle(0);
        check_idle(1);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check_idle(0);
        check_idle(1);

        // Single frame with parity.
        send(0, 4'b1011, 1'b0);
        wait_idle(0);

        // Back-to-back frames with in_valid held high.
        b = bsy_cnt[0];
        send(0, 4'b0001, 1'b1);
        send(0, 4'b1110, 1'b0);
        wait_idle(0);
        check("b2b_busy_cycles", bsy_cnt[0] - b, 14);

        // No parity.
        b = bsy_cnt[1];
        send(1, 4'b0110, 1'b0);
        wait_idle(1);
        check("nopar_busy_cycles", bsy_cnt[1] - b, 6);

        // Reset during DATA bit 2: abort without a clock edge.
        send(0, 4'b1011, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        check("bit2_before_reset", int'(dout[0]), 0);
        rst = 1'b0;
        #1;
        check_idle(0);
        exp0.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_idle(0);
        send(0, 4'b0101, 1'b0);
        wait_idle(0);

        // Randomized bursts, alternating instances.
        for (int blk = 0; blk < 30; blk++) begin
            s  = int'($urandom_range(0, 1));
            nw = int'($urandom_range(1, 4));
            for (int k = 0; k < nw; k++) begin
                send(s, 4'($urandom), (k != nw - 1) && ($urandom_range(0, 1) == 1));
            end
            if ($urandom_range(0, 2) == 0) wait_idle(s);
        end
        wait_idle(0);
        wait_idle(1);
        repeat (3) @(negedge clk);
        check("pending_frames_par", exp0.size(), 0);
        check("pending_frames_nopar", exp1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
